axi_master_demux_r: RTL and testbench
=====================================

AXI_MASTER_DEMUX_R -- requirements
Module: axi_master_demux_r

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, at least 2), giving the number of outstanding read bursts tracked.
REQ-002 SHALL take ID_BITS, DATA_WIDTH and LEN_BITS from the shared define file.
REQ-003 SHALL have port ACLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port ARESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports arvalid, arready, input, 1 bit each: the muxed slave-side AR handshake being observed.
REQ-006 SHALL have port arlen, input, LEN_BITS: the muxed burst length.
REQ-007 SHALL have ports m0_rgrnt, m1_rgrnt, m2_rgrnt, input, 1 bit each: one-hot read grant.
REQ-008 SHALL have port ar_stall, output, 1 bit: tracker full; integration ANDs !ar_stall into arready.
REQ-009 SHALL have slave-side R inputs rid (ID_BITS), rdata (DATA_WIDTH), rresp (2), rlast (1), rvalid (1), and output rready (1).
REQ-010 SHALL have, for each master x in 0..2, outputs mx_RID, mx_RDATA, mx_RRESP, mx_RLAST, mx_RVALID (widths as slave side) and input mx_RREADY (1).
REQ-011 SHALL have port outstanding, output, clog2(DEPTH)+1 bits: count of tracked bursts.
REQ-012 SHALL have ports err_unexpected and err_len, output, 1 bit each: error flags.

Function
REQ-013 SHALL push {master index, arlen} into the tracker FIFO on a cycle where arvalid and arready are both high, grant is exactly one-hot, and the FIFO is not full.
REQ-014 SHALL NOT push on such a handshake when the grant is not one-hot; err_unexpected SHALL pulse 1 cycle.
REQ-015 SHALL drive ar_stall equal to full (outstanding == DEPTH), purely from registered state.
REQ-016 SHALL run a state machine with two states: IDLE (FIFO empty) and ROUTE (head valid); IDLE->ROUTE the cycle after a push; ROUTE->IDLE on pop when no other entry remains.
REQ-017 In ROUTE, SHALL pass the selected master's RID, RDATA, RRESP, RLAST and RVALID from the slave side combinationally with zero latency.
REQ-018 In ROUTE, SHALL drive rready from the selected master's RREADY.
REQ-019 In ROUTE, SHALL hold non-selected masters' RVALID at 0.
REQ-020 In IDLE, SHALL hold rready at 0 and all mx_RVALID at 0.
REQ-021 SHALL hold err_unexpected high in any cycle with rvalid high in IDLE.
REQ-022 SHALL keep a beat counter (LEN_BITS) that increments on each rvalid && rready beat and clears on pop.
REQ-023 SHALL pop the head on the accepted beat where rlast is high or the counter equals the head's arlen.
REQ-024 SHALL pulse err_len for 1 cycle if, on the popping beat, rlast and (counter == arlen) disagree.
REQ-025 SHALL apply a simultaneous push and pop in the same cycle together: outstanding unchanged, pointers wrap modulo DEPTH.
REQ-026 SHALL accept a new burst's first beat in the cycle immediately after the previous burst's last beat, with no bubble.

Reset
REQ-027 While ARESETn is low, SHALL clear FIFO pointers, outstanding, beat counter and error flags, and set state to IDLE.
REQ-028 While ARESETn is low, SHALL hold rready, all mx_RVALID, ar_stall, err_unexpected and err_len at 0.
REQ-029 Reset mid-burst SHALL discard all tracked bursts; no state from before reset SHALL be retained.

Structure
REQ-030 SHALL place the master-select typedef (2-bit: M0, M1, M2) and the tracker-entry struct in the shared package.
REQ-031 SHALL take DEPTH's default from a constant in the shared package.
REQ-032 SHALL implement the tracker as a sub-module axi_rd_track_fifo (synchronous FIFO with full/empty/count outputs).
REQ-033 SHALL keep routing, beat counter and state machine in the top module.

Verification
REQ-034 SHALL verify: m1 grant, arlen=3 handshake, then 4 beats with rlast on beat 4 -> all 4 beats appear on m1 only; outstanding goes 1->0; err_len stays 0.
REQ-035 SHALL verify: push m0 (len 0), m2 (len 1), m1 (len 0) back-to-back -> R beats routed in order m0, m2, m2, m1, with no idle cycle between bursts.
REQ-036 SHALL verify: DEPTH=4 handshakes with no R traffic -> ar_stall=1; a 5th arvalid&&arready (forced) does not push; outstanding stays 4.
REQ-037 SHALL verify: rvalid=1 with the FIFO empty -> err_unexpected=1, rready=0, all mx_RVALID=0.
REQ-038 SHALL verify: arlen=1 with rlast on beat 1 -> err_len pulses, entry pops, next burst routes correctly.
REQ-039 SHALL verify: ARESETn asserted mid-burst (beat 2 of 4) -> outstanding=0 and rready=0 immediately; after release, a new m0 burst routes normally.

Source files
------------

// File: rtl/axi_master_demux_r_pkg.sv
// rtl/axi_master_demux_r_pkg.sv - shared widths, master select and tracker entry types
package axi_master_demux_r_pkg;

  localparam int ID_BITS       = 4;
  localparam int DATA_WIDTH    = 32;
  localparam int LEN_BITS      = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    M0 = 2'd0,
    M1 = 2'd1,
    M2 = 2'd2
  } msel_e;

  typedef struct packed {
    msel_e               msel;
    logic [LEN_BITS-1:0] len;
  } track_entry_t;

  typedef enum logic {
    S_IDLE,
    S_ROUTE
  } state_e;

endpackage

// File: rtl/axi_rd_track_fifo.sv
// rtl/axi_rd_track_fifo.sv - synchronous FIFO of outstanding read bursts
module axi_rd_track_fifo
  import axi_master_demux_r_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  track_entry_t           wdata,
  input  logic                   pop,
  output track_entry_t           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  track_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_master_demux_r.sv
// rtl/axi_master_demux_r.sv - routes slave R beats back to the master that issued each read burst
module axi_master_demux_r
  import axi_master_demux_r_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   arvalid,
  input  logic                   arready,
  input  logic [LEN_BITS-1:0]    arlen,
  input  logic                   m0_rgrnt,
  input  logic                   m1_rgrnt,
  input  logic                   m2_rgrnt,
  output logic                   ar_stall,
  input  logic [ID_BITS-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [ID_BITS-1:0]     m0_RID,
  output logic [DATA_WIDTH-1:0]  m0_RDATA,
  output logic [1:0]             m0_RRESP,
  output logic                   m0_RLAST,
  output logic                   m0_RVALID,
  input  logic                   m0_RREADY,
  output logic [ID_BITS-1:0]     m1_RID,
  output logic [DATA_WIDTH-1:0]  m1_RDATA,
  output logic [1:0]             m1_RRESP,
  output logic                   m1_RLAST,
  output logic                   m1_RVALID,
  input  logic                   m1_RREADY,
  output logic [ID_BITS-1:0]     m2_RID,
  output logic [DATA_WIDTH-1:0]  m2_RDATA,
  output logic [1:0]             m2_RRESP,
  output logic                   m2_RLAST,
  output logic                   m2_RVALID,
  input  logic                   m2_RREADY,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_unexpected,
  output logic                   err_len
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e              state;
  logic [LEN_BITS-1:0] beat_cnt;
  track_entry_t        head;
  track_entry_t        push_entry;
  msel_e               grant_sel;
  msel_e               sel;
  logic [2:0]          grant;
  logic                onehot, ar_hs, push, pop, route, beat, len_hit;
  logic                fifo_full, fifo_empty, err_hs_q;

  assign grant  = {m2_rgrnt, m1_rgrnt, m0_rgrnt};
  assign onehot = (grant == 3'b001) || (grant == 3'b010) || (grant == 3'b100);
  assign ar_hs  = arvalid && arready;
  assign push   = ar_hs && onehot && !fifo_full;

  always_comb begin
    grant_sel = M0;
    if (m1_rgrnt) grant_sel = M1;
    if (m2_rgrnt) grant_sel = M2;
  end

  assign push_entry = '{msel: grant_sel, len: arlen};

  axi_rd_track_fifo #(.DEPTH(DEPTH)) u_track (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  assign ar_stall = fifo_full;
  assign route    = (state == S_ROUTE);
  assign sel      = head.msel;
  assign beat     = route && rvalid && rready;
  assign len_hit  = (beat_cnt == head.len);
  assign pop      = beat && (rlast || len_hit);

  always_comb begin
    rready = 1'b0;
    if (route) begin
      case (sel)
        M0:      rready = m0_RREADY;
        M1:      rready = m1_RREADY;
        M2:      rready = m2_RREADY;
        default: rready = 1'b0;
      endcase
    end
  end

  // Payload fans out to every master; only RVALID qualifies who owns the beat.
  assign m0_RID   = rid;
  assign m0_RDATA = rdata;
  assign m0_RRESP = rresp;
  assign m0_RLAST = rlast;
  assign m1_RID   = rid;
  assign m1_RDATA = rdata;
  assign m1_RRESP = rresp;
  assign m1_RLAST = rlast;
  assign m2_RID   = rid;
  assign m2_RDATA = rdata;
  assign m2_RRESP = rresp;
  assign m2_RLAST = rlast;

  assign m0_RVALID = route && rvalid && (sel == M0);
  assign m1_RVALID = route && rvalid && (sel == M1);
  assign m2_RVALID = route && rvalid && (sel == M2);

  // Stray R data is flagged for as long as it is presented, but never while held in reset.
  assign err_unexpected = err_hs_q || (ARESETn && !route && rvalid);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      err_hs_q <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      err_hs_q <= ar_hs && !onehot;
      err_len  <= pop && (rlast != len_hit);
      if (pop)       beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + LEN_BITS'(1);
      case (state)
        S_IDLE:  if (push) state <= S_ROUTE;
        S_ROUTE: if (pop && !push && (outstanding == CW'(1))) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_demux_r.sv
// tb/tb_axi_master_demux_r.sv - scoreboard bench for the R-channel demux
module tb_axi_master_demux_r;
  import axi_master_demux_r_pkg::*;

  logic                  ACLK, ARESETn;
  logic                  arvalid, arready;
  logic [LEN_BITS-1:0]   arlen;
  logic                  m0_rgrnt, m1_rgrnt, m2_rgrnt;
  logic                  ar_stall;
  logic [ID_BITS-1:0]    rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast, rvalid, rready;
  logic [ID_BITS-1:0]    m0_RID, m1_RID, m2_RID;
  logic [DATA_WIDTH-1:0] m0_RDATA, m1_RDATA, m2_RDATA;
  logic [1:0]            m0_RRESP, m1_RRESP, m2_RRESP;
  logic                  m0_RLAST, m1_RLAST, m2_RLAST;
  logic                  m0_RVALID, m1_RVALID, m2_RVALID;
  logic                  m0_RREADY, m1_RREADY, m2_RREADY;
  logic [2:0]            outstanding;
  logic                  err_unexpected, err_len;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int exp_out = 0;
  bit t35_last [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  axi_master_demux_r dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .m0_rgrnt(m0_rgrnt), .m1_rgrnt(m1_rgrnt), .m2_rgrnt(m2_rgrnt),
    .ar_stall(ar_stall),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .m0_RID(m0_RID), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST),
    .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
    .m1_RID(m1_RID), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST),
    .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY),
    .m2_RID(m2_RID), .m2_RDATA(m2_RDATA), .m2_RRESP(m2_RRESP), .m2_RLAST(m2_RLAST),
    .m2_RVALID(m2_RVALID), .m2_RREADY(m2_RREADY),
    .outstanding(outstanding), .err_unexpected(err_unexpected), .err_len(err_len)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    arvalid = 1'b0; arready = 1'b0; arlen = '0;
    m0_rgrnt = 1'b0; m1_rgrnt = 1'b0; m2_rgrnt = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
  endtask

  task automatic cycle();
    @(posedge ACLK);
    #1;
    clear_inputs();
  endtask

  // AR handshake; the model only tracks it when the grant is one-hot and there is room.
  task automatic ar_drive(input logic [2:0] g, input int len, input int nbeats);
    arvalid = 1'b1; arready = 1'b1; arlen = LEN_BITS'(len);
    {m2_rgrnt, m1_rgrnt, m0_rgrnt} = g;
    if ((g == 3'b001 || g == 3'b010 || g == 3'b100) && exp_out < 4) begin
      exp_out++;
      for (int i = 0; i < nbeats; i++)
        exp_q.push_back(g[0] ? 0 : (g[1] ? 1 : 2));
    end
  endtask

  task automatic r_drive(input logic [DATA_WIDTH-1:0] d, input logic last);
    int m;
    logic [DATA_WIDTH-1:0] got;
    rvalid = 1'b1; rdata = d; rlast = last; rid = d[ID_BITS-1:0]; rresp = 2'b01;
    #1;
    m = (exp_q.size() > 0) ? exp_q.pop_front() : 3;
    check("route", {m2_RVALID, m1_RVALID, m0_RVALID}, 64'(1) << m);
    check("rready", rready, 1);
    case (m)
      0:       got = m0_RDATA;
      1:       got = m1_RDATA;
      default: got = m2_RDATA;
    endcase
    check("rdata", got, d);
    if (last && exp_out > 0) exp_out--;
  endtask

  initial begin
    clear_inputs();
    m0_RREADY = 1'b1; m1_RREADY = 1'b1; m2_RREADY = 1'b1;
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_out", outstanding, 0);
    check("rst_stall", ar_stall, 0);
    check("rst_rready", rready, 0);
    check("rst_valid", {m2_RVALID, m1_RVALID, m0_RVALID}, 0);
    check("rst_errs", {err_unexpected, err_len}, 0);
    ARESETn = 1'b1;
    cycle();

    // single m1 burst of four beats, with one backpressured cycle first
    ar_drive(3'b010, 3, 4);
    cycle();
    check("t34_out1", outstanding, 1);
    rvalid = 1'b1; rdata = 32'hdead; m1_RREADY = 1'b0;
    #1;
    check("t34_bp_rready", rready, 0);
    check("t34_bp_valid", {m2_RVALID, m1_RVALID, m0_RVALID}, 3'b010);
    cycle();
    m1_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_drive(32'h100 + i, i == 3);
      cycle();
      check("t34_errlen", err_len, 0);
    end
    check("t34_out0", outstanding, 0);

    // back-to-back bursts m0, m2, m1 drained with no bubble
    ar_drive(3'b001, 0, 1); cycle();
    ar_drive(3'b100, 1, 2); cycle();
    ar_drive(3'b010, 0, 1); cycle();
    check("t35_out3", outstanding, 3);
    for (int i = 0; i < 4; i++) begin
      r_drive(32'h200 + i, t35_last[i]);
      cycle();
    end
    check("t35_out0", outstanding, 0);
    check("t35_errlen", err_len, 0);

    // push and pop in the same cycle
    ar_drive(3'b001, 0, 1); cycle();
    ar_drive(3'b100, 0, 1);
    r_drive(32'h300, 1'b1);
    cycle();
    check("pp_out", outstanding, exp_out);
    r_drive(32'h301, 1'b1); cycle();
    check("pp_out0", outstanding, 0);

    // non-one-hot grant on a handshake
    ar_drive(3'b011, 0, 1); cycle();
    check("gnt_err", err_unexpected, 1);
    check("gnt_out", outstanding, 0);
    cycle();
    check("gnt_err_pulse", err_unexpected, 0);

    // fill to DEPTH, then a forced extra handshake
    for (int i = 0; i < 4; i++) begin
      ar_drive(3'(1 << (i % 3)), 0, 1);
      cycle();
    end
    check("full_stall", ar_stall, 1);
    check("full_out", outstanding, 4);
    ar_drive(3'b001, 0, 1); cycle();
    check("full_nopush", outstanding, 4);
    check("full_stall2", ar_stall, 1);
    for (int i = 0; i < 4; i++) begin
      r_drive(32'h350 + i, 1'b1);
      cycle();
    end
    check("drain_out", outstanding, 0);
    check("drain_stall", ar_stall, 0);

    // R data with nothing tracked
    rvalid = 1'b1; rdata = 32'hbad;
    #1;
    check("t37_err", err_unexpected, 1);
    check("t37_rready", rready, 0);
    check("t37_valid", {m2_RVALID, m1_RVALID, m0_RVALID}, 0);
    cycle();
    check("t37_out", outstanding, 0);

    // early rlast on a two-beat burst
    ar_drive(3'b100, 1, 1); cycle();
    ar_drive(3'b001, 0, 1); cycle();
    r_drive(32'h400, 1'b1); cycle();
    check("t38_errlen", err_len, 1);
    check("t38_out", outstanding, 1);
    r_drive(32'h401, 1'b1); cycle();
    check("t38_errlen_clr", err_len, 0);
    check("t38_out0", outstanding, 0);

    // reset during beat 2 of a four-beat burst
    ar_drive(3'b010, 3, 4); cycle();
    r_drive(32'h500, 1'b0); cycle();
    rvalid = 1'b1; rdata = 32'h501; ARESETn = 1'b0;
    #1;
    check("t39_out", outstanding, 0);
    check("t39_rready", rready, 0);
    check("t39_valid", {m2_RVALID, m1_RVALID, m0_RVALID}, 0);
    check("t39_flags", {ar_stall, err_unexpected, err_len}, 0);
    exp_q.delete();
    exp_out = 0;
    cycle();
    ARESETn = 1'b1;
    cycle();
    ar_drive(3'b001, 1, 2); cycle();
    r_drive(32'h600, 1'b0); cycle();
    r_drive(32'h601, 1'b1); cycle();
    check("t39_new_out", outstanding, 0);
    check("t39_new_errlen", err_len, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
